uart_tx_fifo_reader: RTL and testbench

- UART transmitter that sits directly downstream of the 8-bit, 16-deep TX FIFO. It pops one byte at a time and serialises it as 8N1 (optionally 8E1) on `tx`.
- Clock and reset are shared with the FIFO. The FIFO updates its registered `dout` on the falling clock edge. This block is entirely rising-edge.
- The block is the last stage before the pad in the UART controller.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_fifo_reader.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path (and the matching receiver).
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high on the last cycle of each CLKS_PER_BIT-cycle period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// 8N1 UART transmitter popping bytes from the TX FIFO (registered dout, falling-edge FIFO).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo_reader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_dout,
    output logic                   fifo_rd,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_W - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   fifo_rd_q, fifo_rd_d;
    logic                   busy_q, busy_d;
    logic                   tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic baud_clear;
    logic baud_tick;

    // Timer is held at zero until the first bit starts so START lasts a full period.
    assign baud_clear = (state_q == IDLE) || (state_q == FETCH);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        fifo_rd_d = 1'b0;
        busy_d    = busy_q;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (en && !fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_dout;
`endif
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d      = UART_IDLE_LVL;
                        bit_idx_d = '0;
                        state_d   = STOP;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    tx_d      = UART_IDLE_LVL;
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // bit_idx is reused to count stop bits
                if (baud_tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        tx_done_d = 1'b1;
                        busy_d    = 1'b0;
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= UART_IDLE_LVL;
            fifo_rd_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            fifo_rd_q <= fifo_rd_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_rd = fifo_rd_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Self-checking bench for uart_tx_fifo_reader with a falling-edge FIFO model and frame-level reference.
module tb_uart_tx_fifo_reader;

    localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int STOPB = 2;
    localparam int PAR   = 1;
`else
    localparam int STOPB = 1;
    localparam int PAR   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(CLKS),
        .STOP_BITS   (STOPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered dout updates on the falling edge after a pop.
    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            chk("rd_while_empty", {31'b0, fifo_empty}, 32'd0);
            if (q.size() > 0) fifo_dout = q.pop_front();
        end
        fifo_empty = (q.size() == 0);
    end

    // Expected line level for bit slot n of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PAR != 0 && n == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (fifo_rd !== 1'b1 && waited < 200);
        chk("pop_seen", {31'b0, fifo_rd}, 32'd1);
    endtask

    // Called just after the pop edge; checks the whole frame through tx_done.
    task automatic check_frame(input logic [7:0] b, input int drop_at);
        logic [7:0] rx;
        int nb;
        nb = 1 + 8 + PAR + STOPB;
        rx = '0;
        chk("busy_at_pop", {31'b0, busy}, 32'd1);
        chk("tx_at_pop", {31'b0, tx}, 32'd1);
        chk("done_pulse_width", {31'b0, tx_done}, 32'd0);
        step();
        chk("rd_one_cycle", {31'b0, fifo_rd}, 32'd0);
        for (int k = 0; k < nb * CLKS; k++) begin
            if (k > 0) step();
            if (k == drop_at) en = 1'b0;
            chk("tx_bit", {31'b0, tx}, {31'b0, frame_bit(b, k / CLKS)});
            chk("done_early", {31'b0, tx_done}, 32'd0);
            if (k / CLKS >= 1 && k / CLKS <= 8 && k % CLKS == CLKS / 2) rx[k / CLKS - 1] = tx;
        end
        chk("rx_byte", {24'b0, rx}, {24'b0, b});
        step();
        chk("tx_done", {31'b0, tx_done}, 32'd1);
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("tx_end", {31'b0, tx}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        int n;
        logic [7:0] bytes[4];

        // Reset
        step();
        step();
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_rd", {31'b0, fifo_rd}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, tx_done}, 32'd0);
        rst = 1'b0;

        // Idle with empty FIFO
        bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single byte
        q.push_back(8'h55);
        wait_pop(w);
        check_frame(8'h55, -1);
        step();
        chk("done_single_pulse", {31'b0, tx_done}, 32'd0);

        // Back-to-back
        q.push_back(8'h01);
        q.push_back(8'h80);
        wait_pop(w);
        check_frame(8'h01, -1);
        wait_pop(w);
        chk("b2b_gap", w, 1);
        check_frame(8'h80, -1);

        // Parity-sensitive bytes
        q.push_back(8'h01);
        q.push_back(8'h03);
        wait_pop(w);
        check_frame(8'h01, -1);
        wait_pop(w);
        chk("b2b_gap2", w, 1);
        check_frame(8'h03, -1);

        // Randomised bursts
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 6)) step();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                bytes[i] = 8'($urandom);
                q.push_back(bytes[i]);
            end
            for (int i = 0; i < n; i++) begin
                wait_pop(w);
                if (i > 0) chk("rand_gap", w, 1);
                check_frame(bytes[i], -1);
            end
        end

        // Enable drop during data bits
        q.push_back(8'hA3);
        q.push_back(8'h5A);
        wait_pop(w);
        check_frame(8'hA3, 3 * CLKS);
        bad = 0;
        repeat (30) begin
            step();
            if (fifo_rd !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("no_pop_en_low", bad, 0);
        chk("fifo_kept", q.size(), 1);
        en = 1'b1;
        wait_pop(w);
        check_frame(8'h5A, -1);

        // Reset mid-frame in data bit 4
        q.push_back(8'hFF);
        q.push_back(8'h3C);
        wait_pop(w);
        step();
        repeat (5 * CLKS + 1) step();
        chk("busy_mid", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", {31'b0, tx}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        bad = 0;
        repeat (3) begin
            step();
            if (tx_done !== 1'b0 || fifo_rd !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("rst_hold_quiet", bad, 0);
        rst = 1'b0;
        wait_pop(w);
        check_frame(8'h3C, -1);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
